// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit holding the HI/LO registers
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_f;
  logic [WIDTH-1:0]   q_f, r_f;
  assign busy = state_q == CALC || state_q == FIXUP;
  assign done = state_q == DONE;
  assign hi = hi_q;
  assign lo = lo_q;
  assign accept = start && !busy;
  // Datapath: operand magnitudes, one shift-add / restoring step, and sign fixup.
  // p_q holds {upper, lower}: for multiply the partial product over the multiplier,
  // for divide the partial remainder over the dividend/quotient bits.
  always_comb begin
    a_neg = !op[0] && operand_a[WIDTH-1];
    b_neg = !op[0] && operand_b[WIDTH-1];
    a_mag = a_neg ? -operand_a : operand_a;
    b_mag = b_neg ? -operand_b : operand_b;
    sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    mul_next = {sum, p_q[WIDTH-1:1]};
    trial = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
    div_next = trial[WIDTH] ? {p_q[2*WIDTH-2:0], 1'b0} : {trial[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
    prod_f = neg_q ? -p_q : p_q;
    q_f = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    r_f = negr_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
  end
  // Next-state: MTHI/MTLO when idle, launch, iterate, then commit the signed result.
  // A zero divisor keeps the quotient unsigned so LO reads all ones for DIV too.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    p_d = p_q;
    b_d = b_q;
    div_d = div_q;
    neg_d = neg_q;
    negr_d = negr_q;
    hi_d = hi_we && !busy ? wdata : hi_q;
    lo_d = lo_we && !busy ? wdata : lo_q;
    if (accept) begin
      state_d = CALC;
      cnt_d = '0;
      div_d = op[1];
      neg_d = (a_neg ^ b_neg) && !(op[1] && operand_b == '0);
      negr_d = a_neg;
      p_d = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
      b_d = op[1] ? b_mag : a_mag;
    end else if (state_q == CALC) begin
      p_d = div_q ? div_next : mul_next;
      cnt_d = cnt_q + 1'b1;
      state_d = cnt_q == CNT_W'(WIDTH - 1) ? FIXUP : CALC;
    end else if (state_q == FIXUP) begin
      {hi_d, lo_d} = div_q ? {r_f, q_f} : prod_f;
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // State registers with asynchronous reset discarding any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      p_q <= '0;
      b_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      negr_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      p_q <= p_d;
      b_q <= b_d;
      div_q <= div_d;
      neg_q <= neg_d;
      negr_q <= negr_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule
